// File: rtl/ls1u_bus_unit_if.sv
// rtl/ls1u_bus_unit_if.sv - cache-side request and bus-side signal bundle of the LS1u bus unit
interface ls1u_bus_unit_if #(
  parameter int BUS_ADDR = 24
) ();
  // cache controller side
  logic                write_through_req;
  logic                read_req;
  logic                read_line_req;
  logic [BUS_ADDR-1:0] pa;
  logic [7:0]          wt_data;
  logic [7:0]          line_data;
  logic [6:0]          addr_count;
  logic                line_write;
  logic                cache_entry_refill;
  logic                trans_rdy;
  logic                bus_error;
  // bus side
  logic [BUS_ADDR-1:0] haddr;
  logic                hwrite;
  logic                hburst;
  logic                htrans;
  logic [7:0]          hwdata;
  logic                hready;
  logic                hresp;
  logic                hreset_n;
  logic [7:0]          hrdata;
  logic                bus_ack;
  logic                bus_req;

  // view of the bus unit itself
  modport master (
    input  write_through_req, read_req, read_line_req, pa, wt_data,
    output line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
    output haddr, hwrite, hburst, htrans, hwdata, bus_req,
    input  hready, hresp, hreset_n, hrdata, bus_ack
  );

  // view of the cache controller plus bus fabric around it
  modport slave (
    output write_through_req, read_req, read_line_req, pa, wt_data,
    input  line_data, addr_count, line_write, cache_entry_refill, trans_rdy, bus_error,
    input  haddr, hwrite, hburst, htrans, hwdata, bus_req,
    output hready, hresp, hreset_n, hrdata, bus_ack
  );
endinterface

// File: rtl/ls1u_bus_unit.sv
// rtl/ls1u_bus_unit.sv - LS1u bus interface unit: write-through, uncached read, 128-byte line refill
module ls1u_bus_unit #(
  parameter int BUS_ADDR = 24
) (
  input  logic             clk,
  input  logic             rst,
  ls1u_bus_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WT   = 3'd1,
    S_RD   = 3'd2,
    S_LINE = 3'd3,
    S_FIN  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [6:0]          r_cnt;
  logic [BUS_ADDR-1:0] r_haddr;
  logic [7:0]          r_hwdata;
  logic [7:0]          r_line_data;
  logic [6:0]          r_addr_count;
  logic                r_line_write;
  logic                r_trans_rdy;
  logic                r_bus_error;
  logic                r_refill;

  logic                w_any_req;
  logic                w_accept;
  logic                w_beat_ok;
  logic                w_beat_err;
  logic                w_htrans;
  logic                w_hwrite;
  logic                w_hburst;
  logic                w_sel_line;
  logic [BUS_ADDR-1:0] w_line_base;

  assign w_any_req   = bus.write_through_req | bus.read_req | bus.read_line_req;
  assign w_sel_line  = ~bus.write_through_req & ~bus.read_req;
  assign w_line_base = {bus.pa[BUS_ADDR-1:7], 7'd0};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode, bus control outputs and beat completion qualifiers
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_beat_ok    = 1'b0;
    w_beat_err   = 1'b0;
    w_htrans     = 1'b0;
    w_hwrite     = 1'b0;
    w_hburst     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.bus_ack && w_any_req) begin
          w_accept = 1'b1;
          if (bus.write_through_req) begin
            w_next_state = S_WT;
          end else if (bus.read_req) begin
            w_next_state = S_RD;
          end else begin
            w_next_state = S_LINE;
          end
        end
      end
      S_WT, S_RD: begin
        w_htrans = 1'b1;
        w_hwrite = (r_state == S_WT);
        if (bus.hready) begin
          w_beat_err   = bus.hresp;
          w_beat_ok    = ~bus.hresp;
          w_next_state = S_DONE;
        end
      end
      S_LINE: begin
        w_htrans = 1'b1;
        w_hburst = 1'b1;
        if (bus.hready) begin
          if (bus.hresp) begin
            w_beat_err   = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_beat_ok = 1'b1;
            if (r_cnt == 7'd127) begin
              w_next_state = S_FIN;
            end
          end
        end
      end
      S_FIN:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    // bus reset aborts whatever is in flight without reporting completion
    if (!bus.hreset_n) begin
      w_next_state = S_IDLE;
      w_accept     = 1'b0;
      w_beat_ok    = 1'b0;
      w_beat_err   = 1'b0;
    end
  end

  // request latching, beat counter, returned data and one-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= 7'd0;
      r_haddr      <= '0;
      r_hwdata     <= 8'd0;
      r_line_data  <= 8'd0;
      r_addr_count <= 7'd0;
      r_line_write <= 1'b0;
      r_trans_rdy  <= 1'b0;
      r_bus_error  <= 1'b0;
      r_refill     <= 1'b0;
    end else begin
      r_line_write <= 1'b0;
      r_trans_rdy  <= 1'b0;
      r_bus_error  <= 1'b0;
      r_refill     <= 1'b0;
      if (!bus.hreset_n) begin
        r_cnt <= 7'd0;
      end else begin
        if (w_accept) begin
          r_cnt    <= 7'd0;
          r_hwdata <= bus.wt_data;
          r_haddr  <= w_sel_line ? w_line_base : bus.pa;
        end
        if (w_beat_err) begin
          r_bus_error <= 1'b1;
        end
        if (w_beat_ok) begin
          case (r_state)
            S_WT: begin
              r_trans_rdy <= 1'b1;
            end
            S_RD: begin
              r_trans_rdy <= 1'b1;
              r_line_data <= bus.hrdata;
            end
            S_LINE: begin
              r_line_write <= 1'b1;
              r_line_data  <= bus.hrdata;
              r_addr_count <= r_cnt;
              r_cnt        <= r_cnt + 7'd1;
              // keep the final byte address on the bus once the burst ends
              if (r_cnt != 7'd127) begin
                r_haddr[6:0] <= r_cnt + 7'd1;
              end
            end
            default: ;
          endcase
        end
        if (r_state == S_FIN) begin
          r_refill    <= 1'b1;
          r_trans_rdy <= 1'b1;
        end
      end
    end
  end

  assign bus.htrans             = w_htrans;
  assign bus.hwrite             = w_hwrite;
  assign bus.hburst             = w_hburst;
  assign bus.haddr              = r_haddr;
  assign bus.hwdata             = r_hwdata;
  assign bus.line_data          = r_line_data;
  assign bus.addr_count         = r_addr_count;
  assign bus.line_write         = r_line_write;
  assign bus.trans_rdy          = r_trans_rdy;
  assign bus.bus_error          = r_bus_error;
  assign bus.cache_entry_refill = r_refill;
  assign bus.bus_req            = ~rst & ((r_state != S_IDLE) | w_any_req);

endmodule

// File: tb/tb_ls1u_bus_unit.sv
// tb/tb_ls1u_bus_unit.sv - scoreboard bench for ls1u_bus_unit with a transaction-level model
module tb_ls1u_bus_unit;
  localparam int BUS_ADDR = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ls1u_bus_unit_if #(.BUS_ADDR(BUS_ADDR)) bus ();

  ls1u_bus_unit #(.BUS_ADDR(BUS_ADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    logic        burst;
    logic [7:0]  wdata;
  } beat_t;

  typedef struct {
    logic [6:0] idx;
    logic [7:0] data;
  } lw_t;

  typedef struct {
    logic       ok;
    logic       refill;
    logic       chk_data;
    logic [7:0] data;
  } end_t;

  beat_t beat_q[$];
  lw_t   lw_q[$];
  end_t  end_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ends_seen = 0;
  int end_cyc = 0;
  int start_cyc = 0;
  int err_beat = -1;
  int beat_idx = 0;
  int stall_left = 0;
  bit rand_ready = 1'b0;

  logic [7:0] mem [256];

  assign bus.hrdata = mem[bus.haddr[7:0]];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // reference model: kind 0 = write-through, 1 = read, 2 = line; err = failing beat or -1
  task automatic expect_txn(int kind, logic [23:0] pa, logic [7:0] wd, int err);
    beat_t b;
    lw_t   l;
    end_t  e;
    logic [23:0] a;
    int nbeats;
    if (kind == 2) begin
      nbeats = (err >= 0) ? err + 1 : 128;
      for (int n = 0; n < nbeats; n++) begin
        a = (pa & 24'hFFFF80) + 24'(n);
        b.addr = a; b.wr = 1'b0; b.burst = 1'b1; b.wdata = 8'd0;
        beat_q.push_back(b);
        if (err < 0 || n < err) begin
          l.idx = 7'(n);
          l.data = mem[a[7:0]];
          lw_q.push_back(l);
        end
      end
    end else begin
      b.addr = pa; b.wr = (kind == 0); b.burst = 1'b0; b.wdata = wd;
      beat_q.push_back(b);
    end
    e.ok = (err < 0);
    e.refill = (kind == 2) && (err < 0);
    e.chk_data = (kind == 1) && (err < 0);
    e.data = mem[pa[7:0]];
    end_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // bus slave: hready pattern and error injection on a chosen beat
  always @(posedge clk) begin
    #1;
    if (!bus.htrans) beat_idx = 0;
    if (bus.htrans && stall_left > 0) begin
      bus.hready = 1'b0;
      stall_left--;
    end else begin
      bus.hready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    bus.hresp = bus.htrans && bus.hready && (beat_idx == err_beat);
    if (bus.htrans && bus.hready) beat_idx++;
  end

  // monitor: compare every observed beat and strobe against the scoreboard
  always @(negedge clk) begin
    beat_t b;
    lw_t   l;
    end_t  e;
    if (!rst) begin
      if (bus.htrans) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) chk("haddr", bus.haddr, beat_q[0].addr);
        if (bus.hready && beat_q.size() != 0) begin
          b = beat_q.pop_front();
          chk("hwrite", bus.hwrite, b.wr);
          chk("hburst", bus.hburst, b.burst);
          if (b.wr) chk("hwdata", bus.hwdata, b.wdata);
        end
      end else begin
        chk("idle_ctl", {bus.hwrite, bus.hburst}, 0);
      end
      if (bus.line_write) begin
        chk("lw_expected", lw_q.size() != 0, 1);
        if (lw_q.size() != 0) begin
          l = lw_q.pop_front();
          chk("addr_count", bus.addr_count, l.idx);
          chk("line_data", bus.line_data, l.data);
        end
      end
      if (bus.trans_rdy || bus.bus_error || bus.cache_entry_refill) begin
        chk("end_expected", end_q.size() != 0, 1);
        if (end_q.size() != 0) begin
          e = end_q.pop_front();
          chk("trans_rdy", bus.trans_rdy, e.ok);
          chk("bus_error", bus.bus_error, !e.ok);
          chk("refill", bus.cache_entry_refill, e.refill);
          if (e.chk_data) chk("rd_data", bus.line_data, e.data);
        end
        ends_seen++;
        end_cyc = cyc;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ends(int target);
    int n = 0;
    while (ends_seen < target && n < 3000) begin
      tick(1);
      n++;
    end
    chk("end_timeout", ends_seen >= target, 1);
  endtask

  task automatic set_req(int kind, logic v);
    case (kind)
      0: bus.write_through_req = v;
      1: bus.read_req = v;
      default: bus.read_line_req = v;
    endcase
  endtask

  task automatic do_txn(int kind, logic [23:0] pa, logic [7:0] wd, int err, int ack_delay);
    int tgt;
    err_beat = err;
    expect_txn(kind, pa, wd, err);
    bus.pa = pa;
    bus.wt_data = wd;
    bus.bus_ack = (ack_delay == 0);
    tgt = ends_seen + 1;
    set_req(kind, 1'b1);
    start_cyc = cyc;
    if (ack_delay > 0) begin
      tick(ack_delay);
      chk("bus_req_wait", bus.bus_req, 1);
      chk("no_htrans_wait", bus.htrans, 0);
      bus.bus_ack = 1'b1;
      start_cyc = cyc;
    end
    wait_ends(tgt);
    set_req(kind, 1'b0);
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.haddr, bus.hwdata, bus.line_data, bus.addr_count, bus.line_write,
            bus.cache_entry_refill, bus.trans_rdy, bus.bus_error, bus.htrans,
            bus.hwrite, bus.hburst, bus.bus_req};
  endfunction

  initial begin
    int tgt;
    bus.write_through_req = 1'b0;
    bus.read_req = 1'b0;
    bus.read_line_req = 1'b0;
    bus.pa = '0;
    bus.wt_data = 8'd0;
    bus.bus_ack = 1'b0;
    bus.hreset_n = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    tick(3);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    tick(2);

    // write-through
    do_txn(0, 24'h001234, 8'hA5, -1, 0);
    chk("wt_latency", end_cyc - start_cyc, 2);
    tick(2);

    // uncached read with two stall cycles
    mem[8'h10] = 8'h3C;
    stall_left = 2;
    do_txn(1, 24'h000010, 8'h00, -1, 0);
    chk("rd_latency", end_cyc - start_cyc, 4);
    tick(2);

    // full line refill, hrdata = beat index
    for (int n = 0; n < 128; n++) mem[8'h80 + n] = 8'(n);
    do_txn(2, 24'h0001C5, 8'h00, -1, 0);
    chk("line_latency", end_cyc - start_cyc, 130);
    tick(2);

    // bus error on beat 5 of a line
    do_txn(2, 24'h000240, 8'h00, 5, 0);
    chk("err_latency", end_cyc - start_cyc, 7);
    tick(2);
    chk("err_back_idle", {bus.bus_req, bus.htrans}, 0);

    // priority and grant: all three requests pending
    err_beat = -1;
    bus.pa = 24'h000321;
    bus.wt_data = 8'h5A;
    expect_txn(0, 24'h000321, 8'h5A, -1);
    expect_txn(1, 24'h000321, 8'h5A, -1);
    expect_txn(2, 24'h000321, 8'h5A, -1);
    bus.bus_ack = 1'b0;
    bus.write_through_req = 1'b1;
    bus.read_req = 1'b1;
    bus.read_line_req = 1'b1;
    tgt = ends_seen;
    tick(3);
    chk("prio_bus_req", bus.bus_req, 1);
    chk("prio_no_htrans", bus.htrans, 0);
    bus.bus_ack = 1'b1;
    wait_ends(tgt + 1);
    bus.write_through_req = 1'b0;
    wait_ends(tgt + 2);
    bus.read_req = 1'b0;
    wait_ends(tgt + 3);
    bus.read_line_req = 1'b0;
    tick(2);

    // reset in the middle of a burst
    expect_txn(2, 24'h000400, 8'h00, -1);
    bus.pa = 24'h000400;
    bus.read_line_req = 1'b1;
    tick(40);
    rst = 1'b1;
    bus.read_line_req = 1'b0;
    #1;
    chk("rst_mid_burst", all_outs(), 0);
    beat_q.delete();
    lw_q.delete();
    end_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
    do_txn(1, 24'h000477, 8'h00, -1, 0);
    chk("rd_after_rst_latency", end_cyc - start_cyc, 2);
    tick(2);

    // randomized traffic with random stalls, grant delays and errors
    rand_ready = 1'b1;
    for (int t = 0; t < 25; t++) begin
      int kind;
      int err;
      kind = $urandom_range(0, 2);
      err = -1;
      if ($urandom_range(0, 3) == 0) err = (kind == 2) ? $urandom_range(0, 127) : 0;
      do_txn(kind, 24'($urandom), 8'($urandom), err, $urandom_range(0, 2));
      tick($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    tick(4);
    chk("queues_empty", beat_q.size() + lw_q.size() + end_q.size(), 0);
    chk("final_idle", bus.bus_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
